panel_stream_writer: RTL
========================

// Module: panel_stream_writer
// PURPOSE
//  Upstream feeder for the LED panel driver's video memory write port. Parses a byte stream
//  (from the Ethernet/UDP receive path) into pixel-write and fill commands. Emits one
//  {R,G,B} memory write per ctrl_clk cycle on the ctrl_* port consumed by the panel driver.
//  Keeps packet and error counters for host-side diagnostics.
// PARAMETERS
//  CHAINED    2   panels in chain; MEM_DEPTH = CHAINED*4096 pixel words (localparam)
//  ADDR_W     16  width of ctrl_addr and of the packet start address
// PORTS
//  ctrl_clk   in   1   clock, all logic on rising edge
//  reset      in   1   synchronous, active-high
//  in_data    in   8   stream byte
//  in_valid   in   1   in_data valid
//  in_last    in   1   qualifies the final byte of a packet (valid only with in_valid)
//  in_ready   out  1   byte accepted when in_valid & in_ready
//  busy       out  1   high while a fill command is executing
//  pkt_count  out  16  good packets completed, wraps at 2^16
//  err_count  out  16  malformed/dropped packets, wraps at 2^16
//  ctrl_en    out  1   memory write strobe, one cycle per pixel
//  ctrl_wr    out  4   4'b0111 when ctrl_en, else 4'b0000 (R,G,B planes)
//  ctrl_addr  out  16  pixel address {row[5:0], col}, always < MEM_DEPTH
//  ctrl_wdat  out  24  {R[7:0],G[7:0],B[7:0]}; consumer keeps its low INPUT_DEPTH bits
// BEHAVIOUR
//  Reset: state=S_CMD, in_ready=0 during reset and 1 the cycle after.
//   ctrl_en=0, ctrl_wr=0, ctrl_addr=0, ctrl_wdat=0, busy=0, counters=0.
//  Packet formats (byte order on stream):
//   0x01 WRITE: cmd, addr_hi, addr_lo, then N x (R,G,B), N>=1. Addresses auto-increment.
//   0x02 FILL : cmd, R, G, B. Writes that colour to addresses 0..MEM_DEPTH-1.
//  FSM states: S_CMD, S_AH, S_AL, S_R, S_G, S_B, S_FILL, S_DROP.
//   S_CMD: 0x01->S_AH; 0x02->S_R with fill flag set.
//    Other code->S_DROP, err++ (or, if in_last, stay in S_CMD with err++).
//   S_AH->S_AL; S_AL latches addr. If addr>=MEM_DEPTH: err++ and ->S_DROP.
//   S_R->S_G->S_B. On B accept (WRITE): registered write, 1-cycle latency
//    (ctrl_en high the cycle after B is accepted). Then addr <= addr+1, wrapping MEM_DEPTH-1 -> 0.
//    If in_last: pkt++ and ->S_CMD; else ->S_R.
//   On B accept (FILL): ->S_FILL, busy=1, in_ready=0. One write per cycle, addr 0..MEM_DEPTH-1.
//    First ctrl_en is the cycle after B is accepted. busy drops with the last write; pkt++.
//    Next state is S_CMD if B carried in_last, else S_DROP. In the S_DROP case, bytes after B
//    are discarded and err is not counted.
//   S_DROP: in_ready=1, discard bytes; on accepted in_last ->S_CMD.
//  Early in_last:
//   - in S_AH/S_AL, or in S_R/S_G of any command: partial data discarded, no write, err++, ->S_CMD.
//   - WRITE pixels already written before in_last stay written.
//  in_ready=1 in all states except S_FILL. No combinational path in_valid->in_ready.
//  pkt/err increment by exactly 1 per packet. Never both for the same packet.
//  Reset mid-packet or mid-fill aborts immediately. No further ctrl_en. Counters cleared.
// STRUCTURE
//  ledcube_pkg: CMD_WRITE=8'h01, CMD_FILL=8'h02, FSM state encodings, MEM_DEPTH function of
//   CHAINED; shared with the panel driver and host-side packet builder.
//  Single module, no sub-modules: FSM, address counter, RGB holding regs, output regs.
// TESTING
//  1. WRITE: 01 00 10, AA BB CC + DD EE FF (last on FF) ->
//     ctrl_addr 0x0010 wdat AABBCC, then 0x0011 DDEEFF; ctrl_wr=7; pkt=1.
//  2. Wrap: WRITE addr 0x1FFF (CHAINED=2), 2 pixels -> writes at 0x1FFF then 0x0000.
//  3. FILL 02 11 22 33 (last) -> busy 8192 cycles, in_ready=0 meanwhile.
//     8192 writes, addr 0..0x1FFF, all 112233; pkt=1.
//  4. Errors: cmd 0x7F + 3 bytes -> err=1, no write.
//     WRITE addr 0x2000 -> err=2, no write.
//     WRITE 01 00 00 AA BB (last on BB) -> err=3, no write.
//  5. Back-to-back: two WRITE packets, in_valid held high -> no dropped byte,
//     writes contiguous, pkt=2, err=0.
//  6. Reset asserted at fill address 100 -> ctrl_en=0 next cycle, busy=0, counters=0.
//     Following WRITE works normally.

Source files
------------

// File: rtl/ledcube_pkg.sv
// ledcube_pkg: constants and types shared by the panel driver, the stream writer and the
// host-side packet builder.
//   CMD_WRITE / CMD_FILL : stream command codes
//   state_e              : stream writer FSM state encodings
//   mem_depth()          : pixel words of video memory for a given number of chained panels
package ledcube_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_FILL  = 8'h02;

  localparam int unsigned PANEL_WORDS = 4096;

  typedef enum logic [2:0] {
    S_CMD,
    S_AH,
    S_AL,
    S_R,
    S_G,
    S_B,
    S_FILL,
    S_DROP
  } state_e;

  function automatic int unsigned mem_depth(input int unsigned chained);
    return chained * PANEL_WORDS;
  endfunction

endpackage

// File: rtl/panel_stream_writer.sv
// panel_stream_writer: parses a byte stream into pixel WRITE and FILL commands and drives the
// panel driver's video memory write port, one {R,G,B} word per cycle.
// Ports:
//   ctrl_clk, reset        clock and synchronous active-high reset
//   in_data/valid/last     input byte stream, in_last marks the final byte of a packet
//   in_ready               byte accepted when in_valid & in_ready (low while filling)
//   busy                   high for every cycle a fill write is on the ctrl_* port
//   pkt_count, err_count   good / malformed packet counters, wrapping
//   ctrl_en/wr/addr/wdat   registered memory write port
module panel_stream_writer
  import ledcube_pkg::*;
#(
  parameter int unsigned CHAINED = 2,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              ctrl_clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count,
  output logic              ctrl_en,
  output logic [3:0]        ctrl_wr,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [23:0]       ctrl_wdat
);

  localparam int unsigned       MemDepth = mem_depth(CHAINED);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MemDepth - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ah_q, ah_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic              fill_q, fill_d;
  logic              fill_last_q, fill_last_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [23:0]       wdat_q, wdat_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic [15:0]       pkt_q, pkt_d;
  logic [15:0]       err_q, err_d;

  logic              accept;
  logic [15:0]       raw_addr;
  logic [ADDR_W-1:0] addr_inc;

  assign accept   = in_valid & in_ready_q;
  assign raw_addr = {ah_q, in_data};
  assign addr_inc = (addr_q == LastAddr) ? '0 : addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ah_d        = ah_q;
    r_d         = r_q;
    g_d         = g_q;
    fill_d      = fill_q;
    fill_last_d = fill_last_q;
    en_d        = 1'b0;
    waddr_d     = waddr_q;
    wdat_d      = wdat_q;
    busy_d      = 1'b0;
    pkt_d       = pkt_q;
    err_d       = err_q;

    unique case (state_q)
      S_CMD: begin
        if (accept) begin
          fill_d = 1'b0;
          if (in_last) begin
            // A command byte alone is a malformed packet; stay aligned on the next packet.
            err_d = err_q + 16'd1;
          end else if (in_data == CMD_WRITE) begin
            state_d = S_AH;
          end else if (in_data == CMD_FILL) begin
            fill_d  = 1'b1;
            state_d = S_R;
          end else begin
            err_d   = err_q + 16'd1;
            state_d = S_DROP;
          end
        end
      end
      S_AH: begin
        if (accept) begin
          if (in_last) begin
            err_d   = err_q + 16'd1;
            state_d = S_CMD;
          end else begin
            ah_d    = in_data;
            state_d = S_AL;
          end
        end
      end
      S_AL: begin
        if (accept) begin
          if (in_last) begin
            err_d   = err_q + 16'd1;
            state_d = S_CMD;
          end else if ({16'h0000, raw_addr} >= MemDepth) begin
            err_d   = err_q + 16'd1;
            state_d = S_DROP;
          end else begin
            addr_d  = ADDR_W'(raw_addr);
            state_d = S_R;
          end
        end
      end
      S_R: begin
        if (accept) begin
          if (in_last) begin
            err_d   = err_q + 16'd1;
            state_d = S_CMD;
          end else begin
            r_d     = in_data;
            state_d = S_G;
          end
        end
      end
      S_G: begin
        if (accept) begin
          if (in_last) begin
            err_d   = err_q + 16'd1;
            state_d = S_CMD;
          end else begin
            g_d     = in_data;
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (accept) begin
          en_d   = 1'b1;
          wdat_d = {r_q, g_q, in_data};
          if (fill_q) begin
            // Word 0 goes out right away; S_FILL streams words 1..MemDepth-1.
            waddr_d     = '0;
            addr_d      = ADDR_W'(1);
            busy_d      = 1'b1;
            fill_last_d = in_last;
            state_d     = S_FILL;
          end else begin
            waddr_d = addr_q;
            addr_d  = addr_inc;
            if (in_last) begin
              pkt_d   = pkt_q + 16'd1;
              state_d = S_CMD;
            end else begin
              state_d = S_R;
            end
          end
        end
      end
      S_FILL: begin
        // wdat_q still holds the fill colour: nothing else writes it during a fill.
        en_d    = 1'b1;
        busy_d  = 1'b1;
        waddr_d = addr_q;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          pkt_d   = pkt_q + 16'd1;
          state_d = fill_last_q ? S_CMD : S_DROP;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DROP: begin
        if (accept && in_last) begin
          state_d = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase

    // Registered so in_ready never depends combinationally on in_valid.
    in_ready_d = ~busy_d;
  end

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      state_q     <= S_CMD;
      addr_q      <= '0;
      ah_q        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      fill_q      <= 1'b0;
      fill_last_q <= 1'b0;
      en_q        <= 1'b0;
      waddr_q     <= '0;
      wdat_q      <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      pkt_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ah_q        <= ah_d;
      r_q         <= r_d;
      g_q         <= g_d;
      fill_q      <= fill_d;
      fill_last_q <= fill_last_d;
      en_q        <= en_d;
      waddr_q     <= waddr_d;
      wdat_q      <= wdat_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      pkt_q       <= pkt_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_q;
  assign err_count = err_q;
  assign ctrl_en   = en_q;
  assign ctrl_wr   = en_q ? 4'b0111 : 4'b0000;
  assign ctrl_addr = waddr_q;
  assign ctrl_wdat = wdat_q;

endmodule
